// File: rtl/latch_bus_seq.sv
// Bus-cycle sequencer for the i386-to-SDRAM address/write/read latch banks.
// Decodes memory cycles, steps the latch G/OE_N controls, hands off to the SDRAM controller and returns READY_N.
module latch_bus_seq #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             ADS_N,
  input  logic             W_R_N,
  input  logic             M_IO_N,
  input  logic             ADDR_HIT,
  input  logic             MEM_ACK,
  input  logic             ERR_CLR,
  output logic             ADDR_G,
  output logic             ADDR_OE_N,
  output logic             WDATA_G,
  output logic             WDATA_OE_N,
  output logic             RDATA_G,
  output logic             RDATA_OE_N,
  output logic             MEM_REQ,
  output logic             MEM_WR,
  output logic             READY_N,
  output logic             BUSY,
  output logic             ERR,
  output logic [CNT_W-1:0] CYC_CNT
);

  localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_REQ,
    S_RCAP,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               mem_wr_q, mem_wr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic addr_g_q, addr_g_d, addr_oe_n_q, addr_oe_n_d;
  logic wdata_g_q, wdata_g_d, wdata_oe_n_q, wdata_oe_n_d;
  logic rdata_g_q, rdata_g_d, rdata_oe_n_q, rdata_oe_n_d;
  logic mem_req_q, mem_req_d, ready_n_q, ready_n_d, busy_q, busy_d;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    mem_wr_d = mem_wr_q;
    tmo_d    = tmo_q;
    err_d    = err_q;
    cnt_d    = cnt_q;

    if (ERR_CLR) err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!ADS_N && M_IO_N && ADDR_HIT) begin
          state_d  = S_LATCH;
          mem_wr_d = W_R_N;
        end
      end
      S_LATCH: begin
        state_d = S_REQ;
        tmo_d   = '0;
      end
      S_REQ: begin
        // The acknowledge is tested first so it beats a coincident timeout.
        if (MEM_ACK) begin
          state_d = mem_wr_q ? S_DONE : S_RCAP;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
          state_d = S_DONE;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_RCAP:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // DONE lasts one cycle, so state_d is DONE only on the entering edge.
    if (state_d == S_DONE) cnt_d = cnt_q + CNT_W'(1);

    // Latch controls decode the next state so they register in step with it.
    addr_g_d     = (state_d == S_LATCH);
    addr_oe_n_d  = !(state_d == S_LATCH || state_d == S_REQ);
    wdata_g_d    = (state_d == S_LATCH) && mem_wr_d;
    wdata_oe_n_d = !((state_d == S_LATCH || state_d == S_REQ) && mem_wr_d);
    rdata_g_d    = (state_d == S_RCAP);
    rdata_oe_n_d = !((state_d == S_RCAP || state_d == S_DONE) && !mem_wr_d);
    mem_req_d    = (state_d == S_REQ);
    ready_n_d    = (state_d != S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments; every flop is reset here because all are control, not storage.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= S_IDLE;
      mem_wr_q     <= 1'b0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      addr_g_q     <= 1'b0;
      addr_oe_n_q  <= 1'b1;
      wdata_g_q    <= 1'b0;
      wdata_oe_n_q <= 1'b1;
      rdata_g_q    <= 1'b0;
      rdata_oe_n_q <= 1'b1;
      mem_req_q    <= 1'b0;
      ready_n_q    <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_wr_q     <= mem_wr_d;
      tmo_q        <= tmo_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      addr_g_q     <= addr_g_d;
      addr_oe_n_q  <= addr_oe_n_d;
      wdata_g_q    <= wdata_g_d;
      wdata_oe_n_q <= wdata_oe_n_d;
      rdata_g_q    <= rdata_g_d;
      rdata_oe_n_q <= rdata_oe_n_d;
      mem_req_q    <= mem_req_d;
      ready_n_q    <= ready_n_d;
      busy_q       <= busy_d;
    end
  end

  assign ADDR_G     = addr_g_q;
  assign ADDR_OE_N  = addr_oe_n_q;
  assign WDATA_G    = wdata_g_q;
  assign WDATA_OE_N = wdata_oe_n_q;
  assign RDATA_G    = rdata_g_q;
  assign RDATA_OE_N = rdata_oe_n_q;
  assign MEM_REQ    = mem_req_q;
  assign MEM_WR     = mem_wr_q;
  assign READY_N    = ready_n_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;
  assign CYC_CNT    = cnt_q;

endmodule

// File: doc/latch_bus_seq.md
Name: latch_bus_seq

Overview:
- Sequences the 9-bit address, write-data and read-data latch banks between the i386 local bus and the SDRAM controller.
- Decodes each i386 memory bus cycle and drives the G (load) and active-low OE controls of each latch bank in order.
- Hands a request to the SDRAM controller, waits for its acknowledge, then returns READY_N to the CPU.
- Includes a timeout so a missing acknowledge cannot hang the CPU.

Parameters:
- TIMEOUT_CYC, 64: maximum REQ-state cycles without MEM_ACK before the cycle is aborted.
- CNT_W, 16: width of the completed-cycle counter.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- ADS_N  in  1  i386 address strobe, active-low.
- W_R_N  in  1  i386 write(1)/read(0), sampled with ADS_N.
- M_IO_N  in  1  i386 memory(1)/IO(0), sampled with ADS_N.
- ADDR_HIT  in  1  address decode hit for the SDRAM window.
- MEM_ACK  in  1  SDRAM controller transfer done, single-cycle pulse.
- ERR_CLR  in  1  clears ERR.
- ADDR_G, ADDR_OE_N  out  1 each  address latch load / output enable.
- WDATA_G, WDATA_OE_N  out  1 each  write-data latch load / output enable.
- RDATA_G, RDATA_OE_N  out  1 each  read-data latch load / output enable.
- MEM_REQ  out  1  request to the SDRAM controller.
- MEM_WR  out  1  request direction, 1 = write.
- READY_N  out  1  i386 READY#, active-low.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky timeout flag.
- CYC_CNT  out  CNT_W  count of completed bus cycles.

Behaviour:
- Reset (RST_N=0, asynchronous), all registered:
  - State = IDLE.
  - All *_G = 0 and all *_OE_N = 1.
  - MEM_REQ = 0, MEM_WR = 0, READY_N = 1, ERR = 0, CYC_CNT = 0.
  - A reset in mid-cycle abandons the cycle; no READY_N pulse is issued.
- States: IDLE, LATCH, REQ, RCAP, DONE.
- IDLE:
  - Moves to LATCH when ADS_N=0, M_IO_N=1 and ADDR_HIT=1 at a clock edge; W_R_N is registered into MEM_WR at that edge.
  - Any other ADS_N (IO cycle or miss) is ignored and the state stays IDLE.
- LATCH (exactly 1 cycle):
  - ADDR_G=1 and ADDR_OE_N=0.
  - If MEM_WR=1, also WDATA_G=1 and WDATA_OE_N=0.
  - Next state REQ.
- REQ:
  - MEM_REQ=1, all G=0.
  - ADDR_OE_N=0 held; WDATA_OE_N=0 held if write.
  - The timeout counter clears on entry and increments each cycle.
  - MEM_ACK=1: read goes to RCAP, write goes to DONE.
  - No MEM_ACK when the counter reaches TIMEOUT_CYC-1: set ERR, then go to DONE (both read and write). Read data is undefined on an aborted cycle.
  - MEM_ACK on the same edge as the timeout: the acknowledge wins and ERR is not set.
- RCAP (1 cycle):
  - MEM_REQ=0, RDATA_G=1, RDATA_OE_N=0.
  - Next state DONE.
- DONE (1 cycle):
  - READY_N=0 and MEM_REQ=0.
  - RDATA_OE_N=0 if read, so the latch drives the CPU data bus.
  - CYC_CNT increments; it wraps from all-ones to 0. It also increments on an aborted cycle.
  - Next state IDLE.
  - All OE_N return to 1 in IDLE.
- Latency: ADS_N sampled at edge 0 puts LATCH in cycle 1 and REQ from cycle 2. With MEM_ACK sampled at edge k:
  - Read: RCAP in cycle k+1, READY_N low in cycle k+2.
  - Write: READY_N low in cycle k+1.
- ADS_N asserted while BUSY=1 is ignored (no queueing).
- A MEM_ACK arriving outside REQ is ignored.
- ERR stays set until ERR_CLR=1. If ERR_CLR and a new timeout occur on the same edge, set wins.
- Outputs are glitch-free registered values. G and OE_N never change in the same cycle as a state transition they do not belong to.

Test Plan:
- Read cycle: ADS_N=0, W_R_N=0, M_IO_N=1, ADDR_HIT=1 at edge 0; MEM_ACK pulse at edge 5 -> ADDR_G=1 only in cycle 1; MEM_REQ=1 cycles 2–5; RDATA_G=1 in cycle 6; READY_N=0 only in cycle 7; CYC_CNT=1.
- Write cycle with MEM_ACK at edge 3 -> WDATA_G=1 and ADDR_G=1 in cycle 1; READY_N=0 in cycle 4; RDATA_G never asserted; MEM_WR=1 throughout.
- Timeout, TIMEOUT_CYC=4, no MEM_ACK -> MEM_REQ high cycles 2–5; READY_N=0 in cycle 6; ERR=1 until ERR_CLR is pulsed, then 0.
- Ignored strobes: ADS_N with M_IO_N=0, or with ADDR_HIT=0 -> no G pulses, BUSY stays 0. A second ADS_N during REQ -> no effect, and exactly one READY_N pulse results.
- Reset mid-REQ: RST_N=0 asynchronously in cycle 3 -> MEM_REQ, ADDR_OE_N and BUSY go inactive immediately; no READY_N pulse; CYC_CNT=0.
- Counter wrap, CNT_W=2: four completed cycles -> CYC_CNT goes 1, 2, 3, 0.
